// File: rtl/onehot_decoder_2x4_seq.sv
// onehot_decoder_2x4_seq
//   Registered binary-to-one-hot decoder with a valid/ready input handshake.
//   Each accepted code drives one line of `out` (or none when in_none=1) for
//   HOLD_CYCLES clocks. A new code can be accepted in the last hold cycle,
//   so codes can be issued back-to-back with no idle cycle between them.
//   Optional feature macro: DECODER_COUNT_EN adds dec_count[7:0], which counts
//   non-empty accepts and wraps from 255 to 0.
//   OUT_W must equal 1<<CODE_W. Any in_code value then maps to exactly one line.
module onehot_decoder_2x4_seq #(
  parameter int CODE_W      = 2,
  parameter int OUT_W       = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_none,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              busy
`ifdef DECODER_COUNT_EN
  ,
  output logic [7:0]        dec_count
`endif
);

  localparam logic [7:0] CNT_INIT = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] out_d;
  logic             ov_d;
  logic [OUT_W-1:0] dec;
  logic             accept;

  // Each output line compares the code against its own index. An empty code
  // clears every line.
  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign dec[i] = ~in_none & (in_code == CODE_W'(i));
  end

  // in_ready is a function of registered state only. This avoids a
  // combinational loop back to the source.
  assign in_ready = (state_q == IDLE) || (cnt_q == 8'd0);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == HOLD);

  // Next-state logic. A reload at cnt==0 keeps the FSM in HOLD, so back-to-back
  // codes do not pass through IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out;
    ov_d    = out_valid;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
          cnt_d   = CNT_INIT;
          out_d   = dec;
          ov_d    = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (accept) begin
          cnt_d = CNT_INIT;
          out_d = dec;
          ov_d  = 1'b1;
        end else begin
          state_d = IDLE;
          out_d   = '0;
          ov_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        out_d   = '0;
        ov_d    = 1'b0;
      end
    endcase
  end

  // State, hold counter and registered outputs. Reset clears out immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out       <= out_d;
      out_valid <= ov_d;
    end
  end

`ifdef DECODER_COUNT_EN
  // Counts non-empty accepts. The counter wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 dec_count <= 8'd0;
    else if (accept && !in_none) dec_count <= dec_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_onehot_decoder_2x4_seq.sv
// Directed bench for onehot_decoder_2x4_seq. Instance d1 uses HOLD_CYCLES=1 and
// instance d3 uses HOLD_CYCLES=3. Both share clk and rst_n.
module tb_onehot_decoder_2x4_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v1 = 1'b0, n1 = 1'b0, v3 = 1'b0, n3 = 1'b0;
  logic [1:0] c1 = '0, c3 = '0;
  logic       r1, ov1, b1, r3, ov3, b3;
  logic [3:0] o1, o3;
`ifdef DECODER_COUNT_EN
  logic [7:0] cnt1, cnt3;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onehot_decoder_2x4_seq #(.CODE_W(2), .OUT_W(4), .HOLD_CYCLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_code(c1),
    .in_none(n1), .out(o1), .out_valid(ov1), .busy(b1)
`ifdef DECODER_COUNT_EN
    , .dec_count(cnt1)
`endif
  );

  onehot_decoder_2x4_seq #(.CODE_W(2), .OUT_W(4), .HOLD_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_code(c3),
    .in_none(n3), .out(o3), .out_valid(ov3), .busy(b3)
`ifdef DECODER_COUNT_EN
    , .dec_count(cnt3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (o1 !== 4'b0000) begin failures++; $display("FAIL reset_out1 got=%b exp=0000", o1); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_ov1 got=%b exp=0", ov1); end
    checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b exp=1", r1); end
    checks++; if (b1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", b1); end
    checks++; if (o3 !== 4'b0000 || ov3 !== 1'b0 || r3 !== 1'b1 || b3 !== 1'b0) begin
      failures++; $display("FAIL reset_d3 got out=%b ov=%b rdy=%b busy=%b exp 0000/0/1/0", o3, ov3, r3, b3);
    end
`ifdef DECODER_COUNT_EN
    checks++; if (cnt1 !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (o1 !== 4'b0000 || ov1 !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got out=%b ov=%b exp 0000/0", o1, ov1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    v1 = 1'b1; n1 = 1'b0; c1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, r1); end
      tick();
      checks++; if (o1 !== exp_tab[i] || ov1 !== 1'b1) begin
        failures++; $display("FAIL b2b_out[%0d] got out=%b ov=%b exp %b/1", i, o1, ov1, exp_tab[i]);
      end
      c1 = 2'(i + 1);
    end
    v1 = 1'b0;
    tick();
    checks++; if (o1 !== 4'b0000 || ov1 !== 1'b0 || b1 !== 1'b0) begin
      failures++; $display("FAIL b2b_drain got out=%b ov=%b busy=%b exp 0000/0/0", o1, ov1, b1);
    end
  endtask

  task automatic test_none();
`ifdef DECODER_COUNT_EN
    logic [7:0] before = cnt1;
`endif
    v1 = 1'b1; n1 = 1'b1; c1 = 2'd2;
    tick();
    v1 = 1'b0; n1 = 1'b0;
    checks++; if (o1 !== 4'b0000 || ov1 !== 1'b1 || b1 !== 1'b1) begin
      failures++; $display("FAIL none_out got out=%b ov=%b busy=%b exp 0000/1/1", o1, ov1, b1);
    end
    tick();
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL none_drop got ov=%b exp=0", ov1); end
`ifdef DECODER_COUNT_EN
    checks++; if (cnt1 !== before) begin failures++; $display("FAIL none_count got=%0d exp=%0d", cnt1, before); end
`endif
  endtask

  task automatic test_hold3();
    @(negedge clk);
    v3 = 1'b1; c3 = 2'd3; n3 = 1'b0;
    tick();
    // The FSM is holding. Present a different code; it must be ignored.
    c3 = 2'd0;
    checks++; if (o3 !== 4'b1000 || r3 !== 1'b0 || b3 !== 1'b1) begin
      failures++; $display("FAIL hold3_c1 got out=%b rdy=%b busy=%b exp 1000/0/1", o3, r3, b3);
    end
    tick();
    v3 = 1'b0;
    checks++; if (o3 !== 4'b1000 || r3 !== 1'b0) begin
      failures++; $display("FAIL hold3_c2 got out=%b rdy=%b exp 1000/0", o3, r3);
    end
    tick();
    checks++; if (o3 !== 4'b1000 || r3 !== 1'b1 || ov3 !== 1'b1) begin
      failures++; $display("FAIL hold3_c3 got out=%b rdy=%b ov=%b exp 1000/1/1", o3, r3, ov3);
    end
    tick();
    checks++; if (o3 !== 4'b0000 || ov3 !== 1'b0 || b3 !== 1'b0 || r3 !== 1'b1) begin
      failures++; $display("FAIL hold3_end got out=%b ov=%b busy=%b rdy=%b exp 0000/0/0/1", o3, ov3, b3, r3);
    end
  endtask

  task automatic test_hold3_reload();
    v3 = 1'b1; c3 = 2'd3;
    tick();
    tick();
    tick();
    // cnt==0: present code 1 for a reload with no idle cycle.
    c3 = 2'd1;
    checks++; if (r3 !== 1'b1) begin failures++; $display("FAIL reload_ready got=%b exp=1", r3); end
    tick();
    v3 = 1'b0;
    checks++; if (o3 !== 4'b0010 || ov3 !== 1'b1 || r3 !== 1'b0) begin
      failures++; $display("FAIL reload_out got out=%b ov=%b rdy=%b exp 0010/1/0", o3, ov3, r3);
    end
    tick(); tick(); tick();
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL reload_end got ov=%b exp=0", ov3); end
  endtask

  task automatic test_reset_mid_hold();
    v1 = 1'b1; c1 = 2'd2;
    tick();
    v1 = 1'b0;
    checks++; if (o1 !== 4'b0100) begin failures++; $display("FAIL midrst_pre got=%b exp=0100", o1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o1 !== 4'b0000 || ov1 !== 1'b0 || b1 !== 1'b0) begin
      failures++; $display("FAIL midrst_async got out=%b ov=%b busy=%b exp 0000/0/0", o1, ov1, b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef DECODER_COUNT_EN
  task automatic test_count();
    @(negedge clk);
    v1 = 1'b1; n1 = 1'b0;
    for (int i = 0; i < 257; i++) begin
      c1 = 2'(i);
      tick();
    end
    v1 = 1'b0;
    checks++; if (cnt1 !== 8'd1) begin failures++; $display("FAIL count_wrap got=%0d exp=1", cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_none();
    test_hold3();
    test_hold3_reload();
    test_reset_mid_hold();
`ifdef DECODER_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
